// File: rtl/sha_block_sequencer.sv
// AXI4-Lite master that pushes one 512-bit message block into a SHA-256 core,
// polls its status register until the digest is ready, then reads back the 256-bit digest.
module sha_block_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h44B0_0000,
  parameter int          POLL_GAP   = 4,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         blk_we,
  input  logic [3:0]   blk_idx,
  input  logic [31:0]  blk_wdata,
  input  logic         start,
  input  logic         first,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [255:0] digest,
  output logic [31:0]  m_axi_awaddr,
  output logic [2:0]   m_axi_awprot,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [31:0]  m_axi_wdata,
  output logic [3:0]   m_axi_wstrb,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic [31:0]  m_axi_araddr,
  output logic [2:0]   m_axi_arprot,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [31:0]  m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] LIMIT_M1 = PW'(POLL_LIMIT - 1);
  localparam logic [7:0]    GAP_M1   = 8'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, WR, WR_RESP, POLL_AR, POLL_R, POLL_WAIT, DIG_AR, DIG_R, FIN, ERR
  } state_t;

  state_t          state, state_next;
  logic [31:0]     msg_buf [16];
  logic [4:0]      entry;
  logic            first_q;
  logic            aw_done, w_done;
  logic [PW-1:0]   poll_cnt;
  logic [7:0]      gap_cnt;
  logic [2:0]      dig_idx;
  logic            aw_hs, w_hs, wr_both;

  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid && m_axi_wready;
  assign wr_both = (aw_done || aw_hs) && (w_done || w_hs);

  assign m_axi_awprot = 3'd0;
  assign m_axi_arprot = 3'd0;
  assign m_axi_wstrb  = 4'hF;

  always_comb begin
    busy          = !(state inside {IDLE, FIN, ERR});
    done          = (state == FIN) || (state == ERR);
    m_axi_awvalid = (state == WR) && !aw_done;
    m_axi_wvalid  = (state == WR) && !w_done;
    m_axi_bready  = (state == WR_RESP);
    m_axi_arvalid = (state == POLL_AR) || (state == DIG_AR);
    m_axi_rready  = (state == POLL_R) || (state == DIG_R);
    m_axi_awaddr  = BASE_ADDR + 32'd4;
    m_axi_wdata   = 32'h4;
    if (entry < 5'd16) begin
      m_axi_awaddr = BASE_ADDR + 32'd20 + {25'd0, entry, 2'b00};
      m_axi_wdata  = msg_buf[entry[3:0]];
    end else if (entry == 5'd16) begin
      m_axi_wdata  = first_q ? 32'h5 : 32'h6;
    end
    m_axi_araddr = (state == DIG_AR) ? BASE_ADDR + 32'd84 + {27'd0, dig_idx, 2'b00} : BASE_ADDR;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Any bad response or an exhausted poll budget funnels into ERR.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, FIN, ERR: state_next = start ? WR : IDLE;
      WR:        if (wr_both) state_next = WR_RESP;
      WR_RESP:   if (m_axi_bvalid) begin
                   if (m_axi_bresp != 2'b00) state_next = ERR;
                   else if (entry == 5'd17)  state_next = POLL_AR;
                   else                      state_next = WR;
                 end
      POLL_AR:   if (m_axi_arready) state_next = POLL_R;
      POLL_R:    if (m_axi_rvalid) begin
                   if (m_axi_rresp != 2'b00)  state_next = ERR;
                   else if (m_axi_rdata[1])   state_next = DIG_AR;
                   else if (poll_cnt == LIMIT_M1) state_next = ERR;
                   else if (POLL_GAP == 0)    state_next = POLL_AR;
                   else                       state_next = POLL_WAIT;
                 end
      POLL_WAIT: if (gap_cnt == GAP_M1) state_next = POLL_AR;
      DIG_AR:    if (m_axi_arready) state_next = DIG_R;
      DIG_R:     if (m_axi_rvalid) begin
                   if (m_axi_rresp != 2'b00) state_next = ERR;
                   else if (dig_idx == 3'd7) state_next = FIN;
                   else                      state_next = DIG_AR;
                 end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 16; i++) msg_buf[i] <= 32'd0;
      entry    <= 5'd0;
      first_q  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      poll_cnt <= '0;
      gap_cnt  <= 8'd0;
      dig_idx  <= 3'd0;
      digest   <= 256'd0;
      error    <= 1'b0;
    end else begin
      if (blk_we && !busy) msg_buf[blk_idx] <= blk_wdata;
      if (start && !busy) begin
        first_q <= first;
        entry   <= 5'd0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        error   <= 1'b0;
      end
      case (state)
        WR: begin
          if (wr_both) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          poll_cnt <= '0;
          if (m_axi_bvalid && m_axi_bresp == 2'b00) entry <= entry + 5'd1;
        end
        POLL_R: begin
          gap_cnt <= 8'd0;
          dig_idx <= 3'd0;
          if (m_axi_rvalid) poll_cnt <= poll_cnt + 1'b1;
        end
        POLL_WAIT: gap_cnt <= gap_cnt + 8'd1;
        DIG_R: begin
          if (m_axi_rvalid && m_axi_rresp == 2'b00) begin
            digest[(7 - int'(dig_idx)) * 32 +: 32] <= m_axi_rdata;
            dig_idx <= dig_idx + 3'd1;
          end
        end
        default: ;
      endcase
      if (state_next == ERR) error <= 1'b1;
    end
  end

endmodule

// File: doc/sha_block_sequencer.md
SHA_BLOCK_SEQUENCER -- requirements
Module: sha_block_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h44B0_0000, meaning the AXI4-Lite base address of the SHA-256 peripheral.
REQ-002 SHALL have parameter POLL_GAP, default 4, meaning the number of idle cycles between status polls (range 0..255).
REQ-003 SHALL have parameter POLL_LIMIT, default 1024, meaning the maximum number of status reads before a timeout.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 blk_we / blk_idx / blk_wdata  in  1/4/32  message-buffer write port (word 0 = most significant).
REQ-007 start / first  in  1/1  start pulse; first=1 selects init, first=0 selects next (chained block).
REQ-008 busy / done / error  out  1/1/1  operation active / 1-cycle completion pulse / sticky fault.
REQ-009 digest  out  256  result; word 0 is digest[255:224].
REQ-010 m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master: 32-bit addr, 32-bit data, wstrb fixed 4'hF, awprot/arprot fixed 0.

Function
REQ-011 SHALL hold a 16x32 message buffer, writable only while busy=0; writes while busy=1 SHALL be ignored.
REQ-012 start while busy=1 SHALL be ignored; start while busy=0 SHALL set busy on the next cycle and clear error.
REQ-013 States SHALL be IDLE, WR, WR_RESP, POLL_AR, POLL_R, POLL_WAIT, DIG_AR, DIG_R, FIN, ERR.
REQ-014 Write list, 18 entries in order: entries 0..15 write buffer word i to BASE_ADDR+20+4*i; entry 16 writes CTRL at BASE_ADDR+4 with 32'h5 (first=1) or 32'h6 (first=0); entry 17 writes 32'h4 to BASE_ADDR+4.
REQ-015 WR: awvalid and wvalid SHALL assert together and each SHALL deassert individually upon its handshake; WR_RESP is entered only when both handshakes have occurred.
REQ-016 WR_RESP: bready=1; on bvalid with bresp=0, advance to the next entry (WR) or, after entry 17, to POLL_AR.
REQ-017 POLL_AR: araddr=BASE_ADDR+0 (STATUS); POLL_R: rready=1; when rdata[1]=1 (digest_valid), go to DIG_AR, otherwise to POLL_WAIT.
REQ-018 POLL_WAIT SHALL idle for exactly POLL_GAP cycles, then return to POLL_AR.
REQ-019 The poll counter SHALL count status reads; a read that is the POLL_LIMIT-th one and has digest_valid=0 SHALL go to ERR.
REQ-020 DIG_AR/DIG_R SHALL read 8 words from BASE_ADDR+84+4*k, k=0..7, one outstanding read at a time, loading digest word k.
REQ-021 digest SHALL be updated only in DIG_R and SHALL hold its value otherwise, including across later errors.
REQ-022 FIN: done=1 for exactly one cycle, busy=0 in the same cycle, next state IDLE.
REQ-023 Any bresp!=0 or rresp!=0 SHALL go to ERR; ERR sets error=1, asserts done for one cycle, clears busy, and returns to IDLE.
REQ-024 At most one AXI transaction SHALL be outstanding; valid signals SHALL never drop before their handshake.
REQ-025 Simultaneous start and blk_we while idle: the buffer write SHALL take effect first, and the sequence SHALL use the new word.

Reset
REQ-026 areset SHALL force IDLE immediately; busy, done, error, all valid and ready outputs, and the counters SHALL be 0; digest SHALL be 0 and the buffer SHALL be 0.
REQ-027 areset asserted mid-transaction SHALL abandon the transaction; no completion pulse SHALL follow.

Verification
REQ-028 Load "abc" block (w0=32'h61626380, w1..w14=0, w15=32'h18), first=1, slave responds OKAY, status valid on 3rd poll -> 18 writes in the order of REQ-014 with CTRL 5 then 4, 3 STATUS reads, 8 digest reads, digest=256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, one done pulse.
REQ-029 Slave delays awready 3 cycles after wready -> wvalid drops after its own handshake, awvalid is held, and exactly one write occurs per entry.
REQ-030 bresp=2'b10 on entry 5 -> error=1, done pulse, no entry-6 write, digest unchanged.
REQ-031 digest_valid never set, POLL_LIMIT=8, POLL_GAP=2 -> exactly 8 STATUS reads spaced by 2 idle cycles, then error=1 and done.
REQ-032 areset during POLL_WAIT -> all outputs 0 and the next start runs the full sequence cleanly; second start with first=0 -> CTRL write is 32'h6.
